// File: rtl/dut_pkg.sv
// Shared definitions for the DUT execute stage.
//   mode_e  : wait-mode encodings carried with each stimulus entry
//   state_e : execute-stage control states
package dut_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED     = 2'b00,
    MODE_TRIG_EQ   = 2'b01,
    MODE_TRIG_NEQ  = 2'b10,
    MODE_IMMEDIATE = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dut_sync_chain.sv
// Multi-stage register chain used to bring an asynchronous bus into the
// clock domain. The output is the input delayed by DEPTH clock edges.
//   clock : sole clock, rising edge
//   reset : synchronous active-high reset, clears every stage
//   d_i   : asynchronous input bus
//   q_o   : synchronised output bus
module dut_sync_chain #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dut_exec_stage.sv
// Execute stage: accepts one stimulus vector per handshake, drives it on
// mosi_data, waits a fixed count or for a masked trigger (bounded by a
// timeout), then captures the synchronised response into a one-entry slot.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   st_valid/st_ready       : stimulus handshake
//   st_mode/st_cycles/st_data : wait mode, count/timeout, test vector
//   trig_mask/trig_value    : trigger compare, static while busy
//   abort                   : cancels a run in progress, no result
//   mosi_data               : registered vector toward the DUT
//   miso_data               : asynchronous DUT response
//   res_valid/res_ready     : result slot handshake
//   res_data/res_cycles/res_timeout : captured response, count, timeout flag
//   busy                    : high while running
//   to_count/to_clear       : saturating timeout counter and its clear
module dut_exec_stage
  import dut_pkg::*;
#(
  parameter int STF_WIDTH   = 24,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int SYNC_STAGES = 2,
  parameter int TOCNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [1:0]             st_mode,
  input  logic [CYCLE_RANGE-1:0] st_cycles,
  input  logic [STF_WIDTH-1:0]   st_data,
  input  logic [RTF_WIDTH-1:0]   trig_mask,
  input  logic [RTF_WIDTH-1:0]   trig_value,
  input  logic                   abort,
  output logic [STF_WIDTH-1:0]   mosi_data,
  input  logic [RTF_WIDTH-1:0]   miso_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RTF_WIDTH-1:0]   res_data,
  output logic [CYCLE_RANGE-1:0] res_cycles,
  output logic                   res_timeout,
  output logic                   busy,
  output logic [TOCNT_WIDTH-1:0] to_count,
  input  logic                   to_clear
);

  logic [RTF_WIDTH-1:0] miso_s;

  dut_sync_chain #(
    .WIDTH (RTF_WIDTH),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (miso_data),
    .q_o   (miso_s)
  );

  state_e                 state_q, state_d;
  mode_e                  mode_q;
  logic [CYCLE_RANGE-1:0] cycles_q;
  logic [CYCLE_RANGE-1:0] cnt_q, cnt_d;
  logic [STF_WIDTH-1:0]   mosi_q;
  logic [RTF_WIDTH-1:0]   res_data_q;
  logic [CYCLE_RANGE-1:0] res_cycles_q;
  logic                   res_timeout_q;
  logic                   res_valid_q;
  logic [TOCNT_WIDTH-1:0] to_count_q;

  logic accept, drain, match, cnt_hit, capture, cap_timeout;

  // Slot is known empty whenever a run starts: accept requires it empty or
  // draining in the same cycle, and nothing else fills it.
  assign st_ready = (state_q == IDLE) && (!res_valid_q || res_ready);
  assign accept   = st_valid && st_ready;
  assign drain    = res_valid_q && res_ready;
  assign match    = ((miso_s ^ trig_value) & trig_mask) == '0;
  assign cnt_hit  = (cnt_q == cycles_q);

  always_comb begin
    capture     = 1'b0;
    cap_timeout = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Abort suppresses any capture that would otherwise happen now.
        if (!abort) begin
          unique case (mode_q)
            MODE_FIXED: capture = cnt_hit;
            MODE_TRIG_EQ: begin
              capture     = match || cnt_hit;
              cap_timeout = !match && cnt_hit;
            end
            MODE_TRIG_NEQ: begin
              capture     = !match || cnt_hit;
              cap_timeout = match && cnt_hit;
            end
            MODE_IMMEDIATE: capture = 1'b1;
            default: capture = cnt_hit;
          endcase
        end
        if (abort || capture) state_d = IDLE;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= MODE_FIXED;
      cycles_q      <= '0;
      cnt_q         <= '0;
      mosi_q        <= '0;
      res_data_q    <= '0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
      res_valid_q   <= 1'b0;
      to_count_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        mosi_q   <= st_data;
        mode_q   <= mode_e'(st_mode);
        cycles_q <= st_cycles;
      end
      if (drain) res_valid_q <= 1'b0;
      if (capture) begin
        res_data_q    <= miso_s;
        res_cycles_q  <= cnt_q;
        res_timeout_q <= cap_timeout;
        res_valid_q   <= 1'b1;
      end
      if (to_clear)                                to_count_q <= '0;
      else if (capture && cap_timeout && !(&to_count_q)) to_count_q <= to_count_q + 1'b1;
    end
  end

  assign mosi_data   = mosi_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_cycles  = res_cycles_q;
  assign res_timeout = res_timeout_q;
  assign busy        = (state_q == RUN);
  assign to_count    = to_count_q;

endmodule

// File: tb/tb_dut_exec_stage.sv
module tb_dut_exec_stage;

  localparam int STF_WIDTH   = 24;
  localparam int RTF_WIDTH   = 24;
  localparam int CYCLE_RANGE = 5;
  localparam int SYNC_STAGES = 2;
  localparam int TOCNT_WIDTH = 3;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   st_valid;
  logic                   st_ready;
  logic [1:0]             st_mode;
  logic [CYCLE_RANGE-1:0] st_cycles;
  logic [STF_WIDTH-1:0]   st_data;
  logic [RTF_WIDTH-1:0]   trig_mask;
  logic [RTF_WIDTH-1:0]   trig_value;
  logic                   abort;
  logic [STF_WIDTH-1:0]   mosi_data;
  logic [RTF_WIDTH-1:0]   miso_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [RTF_WIDTH-1:0]   res_data;
  logic [CYCLE_RANGE-1:0] res_cycles;
  logic                   res_timeout;
  logic                   busy;
  logic [TOCNT_WIDTH-1:0] to_count;
  logic                   to_clear;

  int n_cmp = 0;
  int n_err = 0;

  dut_exec_stage #(
    .STF_WIDTH   (STF_WIDTH),
    .RTF_WIDTH   (RTF_WIDTH),
    .CYCLE_RANGE (CYCLE_RANGE),
    .SYNC_STAGES (SYNC_STAGES),
    .TOCNT_WIDTH (TOCNT_WIDTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_mode     (st_mode),
    .st_cycles   (st_cycles),
    .st_data     (st_data),
    .trig_mask   (trig_mask),
    .trig_value  (trig_value),
    .abort       (abort),
    .mosi_data   (mosi_data),
    .miso_data   (miso_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_cycles  (res_cycles),
    .res_timeout (res_timeout),
    .busy        (busy),
    .to_count    (to_count),
    .to_clear    (to_clear)
  );

  always #5 clock = ~clock;

  // Advance one rising edge, then move 1ns past it to drive and sample.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_mode = 2'b00; st_cycles = '0; st_data = '0;
    trig_mask = '0; trig_value = '0; abort = 1'b0; miso_data = '0;
    res_ready = 1'b1; to_clear = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_mosi",     32'(mosi_data), 32'h0);
    chk("rst_resvalid", 32'(res_valid), 32'h0);
    chk("rst_busy",     32'(busy),      32'h0);
    chk("rst_tocount",  32'(to_count),  32'h0);
    chk("rst_stready",  32'(st_ready),  32'h1);

    // FIXED, cycles=3
    st_valid = 1'b1; st_mode = 2'b00; st_cycles = 5'd3; st_data = 24'hA5A5A5;
    step();
    st_valid = 1'b0;
    chk("t1_mosi",    32'(mosi_data), 32'hA5A5A5);
    chk("t1_busy",    32'(busy),      32'h1);
    chk("t1_stready", 32'(st_ready),  32'h0);
    step(); step(); step();
    chk("t1_notyet",  32'(res_valid), 32'h0);
    step();
    chk("t1_valid",   32'(res_valid),   32'h1);
    chk("t1_cycles",  32'(res_cycles),  32'h3);
    chk("t1_timeout", 32'(res_timeout), 32'h0);
    chk("t1_idle",    32'(busy),        32'h0);
    step();
    chk("t1_drained", 32'(res_valid),   32'h0);

    // TRIG_EQ on low byte 0x42, cycles=20
    trig_mask = 24'h0000FF; trig_value = 24'h000042; miso_data = 24'h123400;
    st_valid = 1'b1; st_mode = 2'b01; st_cycles = 5'd20; st_data = 24'h000001;
    step();
    st_valid = 1'b0;
    step(); step(); step();
    miso_data = 24'h123442;
    step(); step();
    chk("t2_notyet",  32'(res_valid),   32'h0);
    step();
    chk("t2_valid",   32'(res_valid),   32'h1);
    chk("t2_data",    32'(res_data),    32'h123442);
    chk("t2_cycles",  32'(res_cycles),  32'h5);
    chk("t2_timeout", 32'(res_timeout), 32'h0);
    step();

    // TRIG_NEQ with mask=0: never fires, runs to timeout; hold result
    trig_mask = '0; res_ready = 1'b0;
    st_valid = 1'b1; st_mode = 2'b10; st_cycles = 5'd7; st_data = 24'h0C0C0C;
    step();
    st_valid = 1'b0;
    repeat (7) step();
    chk("t3_notyet",  32'(res_valid),   32'h0);
    step();
    chk("t3_valid",   32'(res_valid),   32'h1);
    chk("t3_cycles",  32'(res_cycles),  32'h7);
    chk("t3_timeout", 32'(res_timeout), 32'h1);
    chk("t3_tocount", 32'(to_count),    32'h1);

    // Full slot blocks the next vector; drain + accept in one cycle
    st_valid = 1'b1; st_mode = 2'b11; st_cycles = 5'd9; st_data = 24'h111111;
    #1;
    chk("t4_blocked", 32'(st_ready), 32'h0);
    step();
    chk("t4_noacc_busy", 32'(busy),      32'h0);
    chk("t4_noacc_mosi", 32'(mosi_data), 32'h0C0C0C);
    res_ready = 1'b1;
    #1;
    chk("t4_ready", 32'(st_ready), 32'h1);
    step();
    st_valid = 1'b0;
    chk("t4_drain", 32'(res_valid), 32'h0);
    chk("t4_busy",  32'(busy),      32'h1);
    chk("t4_mosi",  32'(mosi_data), 32'h111111);
    step();
    chk("t4_imm_valid",  32'(res_valid),   32'h1);
    chk("t4_imm_cycles", 32'(res_cycles),  32'h0);
    chk("t4_imm_data",   32'(res_data),    32'h123442);
    chk("t4_imm_to",     32'(res_timeout), 32'h0);
    to_clear = 1'b1;
    step();
    to_clear = 1'b0;
    chk("t3_clear", 32'(to_count), 32'h0);

    // TRIG_EQ with mask=0 fires on the first RUN cycle
    st_valid = 1'b1; st_mode = 2'b01; st_cycles = 5'd15; st_data = 24'h222222;
    step();
    st_valid = 1'b0;
    step();
    chk("eq0_valid",  32'(res_valid),  32'h1);
    chk("eq0_cycles", 32'(res_cycles), 32'h0);
    step();

    // Abort at RUN cycle 2 of FIXED cycles=10
    st_valid = 1'b1; st_mode = 2'b00; st_cycles = 5'd10; st_data = 24'h5A5A5A;
    step();
    st_valid = 1'b0;
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_busy",  32'(busy),      32'h0);
    chk("t5_valid", 32'(res_valid), 32'h0);
    chk("t5_mosi",  32'(mosi_data), 32'h5A5A5A);
    repeat (10) step();
    chk("t5_noresult", 32'(res_valid), 32'h0);

    // Abort coincident with capture
    st_valid = 1'b1; st_mode = 2'b00; st_cycles = 5'd1; st_data = 24'h333333;
    step();
    st_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5c_valid", 32'(res_valid), 32'h0);
    chk("t5c_busy",  32'(busy),      32'h0);
    step();
    chk("t5c_after", 32'(res_valid), 32'h0);

    // Reset mid-RUN
    st_valid = 1'b1; st_mode = 2'b00; st_cycles = 5'd5; st_data = 24'h777777;
    step();
    st_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_mosi", 32'(mosi_data), 32'h0);
    chk("t6_busy", 32'(busy),      32'h0);

    // Reset with a held result
    miso_data = 24'h0ABCDE; res_ready = 1'b0;
    repeat (3) step();
    st_valid = 1'b1; st_mode = 2'b11; st_cycles = 5'd0; st_data = 24'h444444;
    step();
    st_valid = 1'b0;
    step();
    chk("t6_held",      32'(res_valid), 32'h1);
    chk("t6_held_data", 32'(res_data),  32'h0ABCDE);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_valid", 32'(res_valid), 32'h0);
    chk("t6_rst_data",  32'(res_data),  32'h0);
    chk("t6_rst_mosi",  32'(mosi_data), 32'h0);
    res_ready = 1'b1;

    // Nine back-to-back timeouts saturate the 3-bit counter at 7
    trig_mask = '0;
    st_valid = 1'b1; st_mode = 2'b10; st_cycles = 5'd0; st_data = 24'h555555;
    repeat (18) step();
    st_valid = 1'b0;
    chk("t6_sat_timeout", 32'(res_timeout), 32'h1);
    step(); step();
    chk("t6_saturated", 32'(to_count), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
